mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: XLEN, default 32, data word width; ADDR_WIDTH, default 32, word-address width.
REQ-002 Port clk  input  1  sole clock; all state updates on posedge.
REQ-003 Port reset  input  1  asynchronous, active-low reset.
REQ-004 Port i_req_valid  input  1  instruction-fetch read request.
REQ-005 Port i_req_addr  input  ADDR_WIDTH  fetch word address.
REQ-006 Port i_req_ready  output  1  fetch request accepted this cycle.
REQ-007 Port i_resp_valid / i_resp_data  output  1 / XLEN  fetch response and read word.
REQ-008 Port i_resp_ready  input  1  fetch consumer accepts the response.
REQ-009 Port d_req_valid / d_req_addr / d_req_we / d_req_wdata  input  1 / ADDR_WIDTH / 1 / XLEN  load/store request.
REQ-010 Port d_req_ready  output  1  data request accepted this cycle.
REQ-011 Port d_resp_valid / d_resp_data  output  1 / XLEN  data response and read word.
REQ-012 Port d_resp_ready  input  1  data consumer accepts the response.
REQ-013 Ports mem_address (out, ADDR_WIDTH), mem_write_en (out, 1), mem_data_in (out, XLEN) and mem_data_out (in, XLEN) SHALL connect to the single-port memory, which has a combinational read and a posedge write.

Function
REQ-014 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-015 In IDLE with at least one valid request, the block SHALL choose a winner, pulse that port's req_ready, latch its addr/we/wdata (we=0 for fetch), record the granted port, and move to ACCESS.
REQ-016 In IDLE with no valid request, the block SHALL stay in IDLE with both req_ready signals 0.
REQ-017 At most one req_ready SHALL be high in any cycle, and it SHALL be high only in IDLE.
REQ-018 In ACCESS, the block SHALL drive mem_address from the latched address, mem_data_in from the latched wdata and mem_write_en from the latched we, capture mem_data_out into the response register at the clock edge, and move to RESP.
REQ-019 For a write, the response data SHALL be the word's contents before the write, because the read is combinational in the ACCESS cycle.
REQ-020 In RESP, the block SHALL hold the granted port's resp_valid high with stable data until resp_ready is high, then return to IDLE on that edge.
REQ-021 Minimum latency SHALL be: request accepted at edge N, resp_valid high in the cycle after edge N+1, and a new grant no earlier than the cycle after the response handshake.
REQ-022 mem_write_en SHALL be 0 in every state except ACCESS, and mem_address SHALL always show the latched address.
REQ-023 A non-granted port's resp_valid SHALL be 0, and its resp_data SHALL hold its last value.
REQ-024 Requesters SHALL hold valid and payload until ready; a request withdrawn before ready SHALL NOT be serviced.

Reset
REQ-025 When reset is low, the block SHALL go to IDLE at once, without waiting for a clock edge.
REQ-026 While reset is low, mem_write_en SHALL be 0, even if reset asserts during ACCESS.
REQ-027 Reset SHALL set to 0: all ready/valid outputs, both resp_data registers, the latched address/wdata/we, and mem_address.
REQ-028 Reset SHALL set last_grant to D.
REQ-029 A transaction in flight at reset SHALL be dropped, with no response.

Configuration
REQ-030 With MEM_ARB_ROUND_ROBIN_EN defined, when both ports request in IDLE, the grant SHALL go to the port that was not last_grant, and last_grant SHALL update on every grant.
REQ-031 With MEM_ARB_ROUND_ROBIN_EN undefined, the data port SHALL always win a conflict, and last_grant SHALL be absent or unused.
REQ-032 A lone requester SHALL be granted in IDLE in both configurations.

Verification
REQ-033 Fetch only: mem[0x10]=0xDEADBEEF, i_req addr 0x10, i_resp_ready=1 -> i_req_ready at cycle 0, i_resp_valid with 0xDEADBEEF at cycle 2, back to IDLE at cycle 3.
REQ-034 Store then load: d_req we=1, addr 0x4, wdata 0x12345678, then load 0x4 -> store response carries the old contents (0x0), load returns 0x12345678, mem_write_en high for exactly one cycle.
REQ-035 Conflict: both request every cycle for 4 transactions -> with the macro, grants go I,D,I,D; without it, grants go D,D,D,D and i_req_ready stays 0.
REQ-036 Backpressure: d_resp_ready held 0 for 5 cycles -> d_resp_valid and data stay stable, no new grant, and i_req_ready stays 0 until the handshake.
REQ-037 Reset during ACCESS of a store to 0x8 -> mem_write_en drops in the same cycle, mem[0x8] is unchanged, FSM is in IDLE, and no response is issued.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-port memory with combinational read.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate grants on conflict; otherwise the data port always wins.
module mem_arbiter #(
   parameter int XLEN       = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_req_valid,
   input  logic [ADDR_WIDTH-1:0] i_req_addr,
   output logic                  i_req_ready,
   output logic                  i_resp_valid,
   output logic [XLEN-1:0]       i_resp_data,
   input  logic                  i_resp_ready,
   input  logic                  d_req_valid,
   input  logic [ADDR_WIDTH-1:0] d_req_addr,
   input  logic                  d_req_we,
   input  logic [XLEN-1:0]       d_req_wdata,
   output logic                  d_req_ready,
   output logic                  d_resp_valid,
   output logic [XLEN-1:0]       d_resp_data,
   input  logic                  d_resp_ready,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic                  mem_write_en,
   output logic [XLEN-1:0]       mem_data_in,
   input  logic [XLEN-1:0]       mem_data_out
);

   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_e;

   localparam logic GNT_I = 1'b0;
   localparam logic GNT_D = 1'b1;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [XLEN-1:0]       wdata_q, wdata_d;
   logic                  we_q, we_d;
   logic                  gnt_q, gnt_d;
   logic [XLEN-1:0]       i_rdata_q, i_rdata_d;
   logic [XLEN-1:0]       d_rdata_q, d_rdata_d;
   logic                  pick_d;
   logic                  resp_hs;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic last_grant_q, last_grant_d;

   always_comb begin
      pick_d = d_req_valid && (!i_req_valid || (last_grant_q == GNT_I));
   end
`else
   always_comb begin
      pick_d = d_req_valid;
   end
`endif

   assign resp_hs = (gnt_q == GNT_D) ? d_resp_ready : i_resp_ready;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (i_req_valid || d_req_valid) state_d = ACCESS;
         ACCESS:  state_d = RESP;
         RESP:    if (resp_hs) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic; ready and write enable are gated by reset so they drop without a clock.
   always_comb begin
      i_req_ready  = reset && (state_q == IDLE) && i_req_valid && !pick_d;
      d_req_ready  = reset && (state_q == IDLE) && pick_d;
      i_resp_valid = (state_q == RESP) && (gnt_q == GNT_I);
      d_resp_valid = (state_q == RESP) && (gnt_q == GNT_D);
      mem_write_en = reset && (state_q == ACCESS) && we_q;
      mem_address  = addr_q;
      mem_data_in  = wdata_q;
      i_resp_data  = i_rdata_q;
      d_resp_data  = d_rdata_q;
   end

   // Request latch and response capture
   always_comb begin
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      we_d      = we_q;
      gnt_d     = gnt_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      if (d_req_ready) begin
         addr_d  = d_req_addr;
         wdata_d = d_req_wdata;
         we_d    = d_req_we;
         gnt_d   = GNT_D;
      end else if (i_req_ready) begin
         addr_d  = i_req_addr;
         wdata_d = '0;
         we_d    = 1'b0;
         gnt_d   = GNT_I;
      end
      // Read happens in the same cycle as any write, so a store returns the old word.
      if (state_q == ACCESS) begin
         if (gnt_q == GNT_D) d_rdata_d = mem_data_out;
         else                i_rdata_d = mem_data_out;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q    <= '0;
         wdata_q   <= '0;
         we_q      <= 1'b0;
         gnt_q     <= GNT_D;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         we_q      <= we_d;
         gnt_q     <= gnt_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end

`ifdef MEM_ARB_ROUND_ROBIN_EN
   always_comb begin
      last_grant_d = last_grant_q;
      if (d_req_ready)      last_grant_d = GNT_D;
      else if (i_req_ready) last_grant_d = GNT_I;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) last_grant_q <= GNT_D;
      else        last_grant_q <= last_grant_d;
   end
`endif

   a_one_ready: assert property (@(posedge clk) disable iff (!reset)
      !(i_req_ready && d_req_ready));
   a_wen_access: assert property (@(posedge clk) disable iff (!reset)
      mem_write_en |-> (state_q == ACCESS));
   a_ready_idle: assert property (@(posedge clk) disable iff (!reset)
      (i_req_ready || d_req_ready) |-> (state_q == IDLE));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single transactions plus
// conflict, backpressure and reset-during-access sequences.
module tb_mem_arbiter;
   localparam int XLEN = 32;
   localparam int AW   = 32;
`ifdef MEM_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset;
   logic            i_req_valid, i_req_ready, i_resp_valid, i_resp_ready;
   logic [AW-1:0]   i_req_addr;
   logic [XLEN-1:0] i_resp_data;
   logic            d_req_valid, d_req_we, d_req_ready, d_resp_valid, d_resp_ready;
   logic [AW-1:0]   d_req_addr;
   logic [XLEN-1:0] d_req_wdata, d_resp_data;
   logic [AW-1:0]   mem_address;
   logic            mem_write_en;
   logic [XLEN-1:0] mem_data_in, mem_data_out;

   mem_arbiter #(.XLEN(XLEN), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset(reset),
      .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
      .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data), .i_resp_ready(i_resp_ready),
      .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_we(d_req_we),
      .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
      .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data), .d_resp_ready(d_resp_ready),
      .mem_address(mem_address), .mem_write_en(mem_write_en),
      .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
   );

   always #5 clk = ~clk;

   // Memory model: combinational read, posedge write, clear-and-preload on mem_clr.
   logic [31:0] mem [0:255];
   logic        mem_clr;
   int          wen_cycles = 0;
   assign mem_data_out = mem[mem_address[7:0]];
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int k = 0; k < 256; k++) mem[k] <= 32'h0;
         mem[8'h10] <= 32'hDEADBEEF;
         mem[8'hFF] <= 32'hFFFF_FFFF;
      end else if (mem_write_en) begin
         mem[mem_address[7:0]] <= mem_data_in;
      end
      if (mem_write_en) wen_cycles <= wen_cycles + 1;
   end

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] exp_i_data = 32'h0;
   logic [31:0] exp_d_data = 32'h0;

   task automatic chk1(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        is_d;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   // One transaction with both resp_ready high: ready at cycle 0, ACCESS at 1, RESP at 2, IDLE at 3.
   task automatic run_txn(input vec_t v);
      int wen0;
      wen0 = wen_cycles;
      if (v.is_d) begin
         d_req_valid = 1'b1; d_req_addr = v.addr; d_req_we = v.we; d_req_wdata = v.wdata;
      end else begin
         i_req_valid = 1'b1; i_req_addr = v.addr;
      end
      #1;
      chk1("grant_d", d_req_ready, v.is_d);
      chk1("grant_i", i_req_ready, !v.is_d);
      tick();
      i_req_valid = 1'b0; d_req_valid = 1'b0;
      #1;
      chk1("access_wen", mem_write_en, v.we);
      chk32("access_addr", mem_address, v.addr);
      chk1("access_no_ready", i_req_ready | d_req_ready, 1'b0);
      tick();
      chk1("resp_valid", v.is_d ? d_resp_valid : i_resp_valid, 1'b1);
      chk1("resp_other_idle", v.is_d ? i_resp_valid : d_resp_valid, 1'b0);
      chk32("resp_data", v.is_d ? d_resp_data : i_resp_data, v.exp);
      chk32("other_data_held", v.is_d ? i_resp_data : d_resp_data, v.is_d ? exp_i_data : exp_d_data);
      if (v.is_d) exp_d_data = v.exp; else exp_i_data = v.exp;
      tick();
      chk1("back_idle", d_resp_valid | i_resp_valid, 1'b0);
      chk32("wen_cycles", wen_cycles - wen0, v.we ? 32'd1 : 32'd0);
   endtask

   vec_t vecs[8];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,         32'hDEADBEEF};
      vecs[1] = '{1'b1, 1'b1, 32'h4,  32'h12345678,  32'h0};
      vecs[2] = '{1'b1, 1'b0, 32'h4,  32'h0,         32'h12345678};
      vecs[3] = '{1'b1, 1'b1, 32'h4,  32'hCAFEF00D,  32'h12345678};
      vecs[4] = '{1'b0, 1'b0, 32'h4,  32'h0,         32'hCAFEF00D};
      vecs[5] = '{1'b0, 1'b0, 32'hFF, 32'h0,         32'hFFFF_FFFF};
      vecs[6] = '{1'b1, 1'b1, 32'hFF, 32'h0,         32'hFFFF_FFFF};
      vecs[7] = '{1'b1, 1'b0, 32'hFF, 32'h0,         32'h0};

      // Reset with both requesters pushing: nothing may be granted.
      reset = 1'b0; mem_clr = 1'b1;
      i_req_valid = 1'b1; i_req_addr = 32'h10;
      d_req_valid = 1'b1; d_req_addr = 32'h4; d_req_we = 1'b1; d_req_wdata = 32'h1;
      i_resp_ready = 1'b1; d_resp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk1("rst_i_ready", i_req_ready, 1'b0);
      chk1("rst_d_ready", d_req_ready, 1'b0);
      chk1("rst_resp_valid", i_resp_valid | d_resp_valid, 1'b0);
      chk1("rst_wen", mem_write_en, 1'b0);
      chk32("rst_addr", mem_address, 32'h0);
      chk32("rst_i_data", i_resp_data, 32'h0);
      chk32("rst_d_data", d_resp_data, 32'h0);
      i_req_valid = 1'b0; d_req_valid = 1'b0; d_req_we = 1'b0;
      mem_clr = 1'b0; reset = 1'b1;
      tick();

      for (int n = 0; n < 8; n++) run_txn(vecs[n]);

      // Conflict: both ports request every cycle for four grants, from a fresh reset.
      reset = 1'b0; #2; reset = 1'b1;
      exp_i_data = 32'h0; exp_d_data = 32'h0;
      tick();
      i_req_valid = 1'b1; i_req_addr = 32'h10;
      d_req_valid = 1'b1; d_req_addr = 32'h4; d_req_we = 1'b0;
      #1;
      for (int t = 0; t < 4; t++) begin
         logic exp_d;
         exp_d = RR ? ((t % 2) == 1) : 1'b1;
         chk1("conflict_d_ready", d_req_ready, exp_d);
         chk1("conflict_i_ready", i_req_ready, !exp_d);
         tick();
         tick();
         chk32("conflict_data", exp_d ? d_resp_data : i_resp_data,
               exp_d ? 32'hCAFEF00D : 32'hDEADBEEF);
         if (exp_d) exp_d_data = 32'hCAFEF00D; else exp_i_data = 32'hDEADBEEF;
         tick();
      end
      i_req_valid = 1'b0; d_req_valid = 1'b0;
      #1;

      // Backpressure: data response stalled while a fetch waits.
      d_resp_ready = 1'b0;
      d_req_valid = 1'b1; d_req_addr = 32'h10; d_req_we = 1'b0;
      #1;
      chk1("bp_d_grant", d_req_ready, 1'b1);
      tick();
      d_req_valid = 1'b0;
      i_req_valid = 1'b1; i_req_addr = 32'hFF;
      tick();
      for (int k = 0; k < 5; k++) begin
         chk1("bp_d_valid", d_resp_valid, 1'b1);
         chk32("bp_d_data", d_resp_data, 32'hDEADBEEF);
         chk1("bp_no_grant", i_req_ready | d_req_ready, 1'b0);
         chk1("bp_i_valid", i_resp_valid, 1'b0);
         chk32("bp_i_data_held", i_resp_data, exp_i_data);
         tick();
      end
      d_resp_ready = 1'b1;
      #1;
      chk1("bp_hs_no_grant", i_req_ready, 1'b0);
      tick();
      chk1("bp_after_d_valid", d_resp_valid, 1'b0);
      chk1("bp_after_i_grant", i_req_ready, 1'b1);
      tick();
      i_req_valid = 1'b0;
      tick();
      chk1("bp_i_resp_valid", i_resp_valid, 1'b1);
      chk32("bp_i_resp_data", i_resp_data, 32'h0);
      exp_i_data = 32'h0;
      exp_d_data = 32'hDEADBEEF;
      tick();

      // Reset in the ACCESS cycle of a store to 0x8.
      d_req_valid = 1'b1; d_req_addr = 32'h8; d_req_we = 1'b1; d_req_wdata = 32'hA5A5A5A5;
      #1;
      chk1("rs_grant", d_req_ready, 1'b1);
      tick();
      d_req_valid = 1'b0;
      chk1("rs_wen_before", mem_write_en, 1'b1);
      #2 reset = 1'b0;
      #1;
      chk1("rs_wen_dropped", mem_write_en, 1'b0);
      chk1("rs_no_ready", d_req_ready | i_req_ready, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      chk32("rs_mem_unchanged", mem[8'h08], 32'h0);
      exp_i_data = 32'h0; exp_d_data = 32'h0;
      for (int k = 0; k < 3; k++) begin
         chk1("rs_no_resp", d_resp_valid | i_resp_valid, 1'b0);
         tick();
      end
      chk32("rs_d_data_cleared", d_resp_data, 32'h0);
      run_txn('{1'b1, 1'b0, 32'h8, 32'h0, 32'h0});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
